// File: rtl/tour_cmd_sequencer_if.sv
// Command/response bundle between the tour sequencer and its neighbours:
// UART_wrapper command input, cmd_proc command output and handshakes, and the response byte.
interface tour_cmd_sequencer_if;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic [7:0]  resp;

    modport master (
        input  cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        output cmd, cmd_rdy, resp
    );

    modport slave (
        output cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        input  cmd, cmd_rdy, resp
    );
endinterface

// File: rtl/tour_cmd_sequencer.sv
// Replays a stored knight's tour to cmd_proc as vertical-then-horizontal move commands;
// when idle, UART commands pass straight through.
module tour_cmd_sequencer #(
    parameter int NUM_MOVES = 24,
    localparam int IW = (NUM_MOVES > 1) ? $clog2(NUM_MOVES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_tour,
    output logic [IW-1:0] mv_indx,
    input  logic [7:0]    move,
    output logic          tour_busy,
    tour_cmd_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, VERT_ISSUE, VERT_ACK, VERT_DONE, HORZ_ISSUE, HORZ_ACK, HORZ_DONE, ABORT
    } state_t;

    localparam logic [3:0]    OP_VERT  = 4'h4;
    localparam logic [3:0]    OP_HORZ  = 4'h5;
    localparam logic [7:0]    HDG_N    = 8'h00;
    localparam logic [7:0]    HDG_W    = 8'h3F;
    localparam logic [7:0]    HDG_S    = 8'h7F;
    localparam logic [7:0]    HDG_E    = 8'hBF;
    localparam logic [7:0]    RESP_ACK = 8'hA5;
    localparam logic [7:0]    RESP_END = 8'h5A;
    localparam logic [7:0]    RESP_ERR = 8'hEE;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MOVES - 1);

    function automatic logic is_one_hot(input logic [7:0] m);
        return (m != 8'h00) && ((m & (m - 8'h01)) == 8'h00);
    endfunction

    function automatic logic [15:0] vert_cmd(input logic [7:0] m);
        case (m)
            8'h01, 8'h02: return {OP_VERT, HDG_N, 4'd2};
            8'h04, 8'h80: return {OP_VERT, HDG_N, 4'd1};
            8'h08, 8'h40: return {OP_VERT, HDG_S, 4'd1};
            8'h10, 8'h20: return {OP_VERT, HDG_S, 4'd2};
            default:      return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] horz_cmd(input logic [7:0] m);
        case (m)
            8'h01, 8'h20: return {OP_HORZ, HDG_E, 4'd1};
            8'h02, 8'h10: return {OP_HORZ, HDG_W, 4'd1};
            8'h04, 8'h08: return {OP_HORZ, HDG_W, 4'd2};
            8'h40, 8'h80: return {OP_HORZ, HDG_E, 4'd2};
            default:      return 16'h0000;
        endcase
    endfunction

    state_t        state_r, state_nxt_s;
    logic [IW-1:0] mv_indx_r, mv_indx_nxt_s;
    logic [7:0]    move_lat_r, move_lat_nxt_s;
    logic [15:0]   cmd_seq_r, cmd_seq_nxt_s;
    logic          cmd_rdy_seq_r, cmd_rdy_seq_nxt_s;
    logic [7:0]    resp_r, resp_nxt_s;
    logic          tour_busy_r, tour_busy_nxt_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; a clr_cmd_rdy in an ACK state only ever advances one step
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:       if (start_tour) state_nxt_s = VERT_ISSUE; else state_nxt_s = IDLE;
            VERT_ISSUE: if (!is_one_hot(move)) state_nxt_s = ABORT; else state_nxt_s = VERT_ACK;
            VERT_ACK:   if (bus.clr_cmd_rdy) state_nxt_s = VERT_DONE; else state_nxt_s = VERT_ACK;
            VERT_DONE:  if (bus.send_resp) state_nxt_s = HORZ_ISSUE; else state_nxt_s = VERT_DONE;
            HORZ_ISSUE: state_nxt_s = HORZ_ACK;
            HORZ_ACK:   if (bus.clr_cmd_rdy) state_nxt_s = HORZ_DONE; else state_nxt_s = HORZ_ACK;
            HORZ_DONE: begin
                if (bus.send_resp) begin
                    if (mv_indx_r == LAST_IDX) state_nxt_s = IDLE; else state_nxt_s = VERT_ISSUE;
                end else begin
                    state_nxt_s = HORZ_DONE;
                end
            end
            ABORT:      state_nxt_s = IDLE;
            default:    state_nxt_s = IDLE;
        endcase
    end

    // Next values of the registered outputs and the latched move
    always_comb begin
        mv_indx_nxt_s     = mv_indx_r;
        move_lat_nxt_s    = move_lat_r;
        cmd_seq_nxt_s     = cmd_seq_r;
        cmd_rdy_seq_nxt_s = cmd_rdy_seq_r;
        resp_nxt_s        = resp_r;
        tour_busy_nxt_s   = tour_busy_r;
        case (state_r)
            IDLE: begin
                if (start_tour) begin
                    mv_indx_nxt_s   = '0;
                    tour_busy_nxt_s = 1'b1;
                    resp_nxt_s      = RESP_ACK;
                end else begin
                    tour_busy_nxt_s = 1'b0;
                end
            end
            VERT_ISSUE: begin
                if (!is_one_hot(move)) begin
                    cmd_rdy_seq_nxt_s = 1'b0;
                    resp_nxt_s        = RESP_ERR;
                end else begin
                    move_lat_nxt_s    = move;
                    cmd_seq_nxt_s     = vert_cmd(move);
                    cmd_rdy_seq_nxt_s = 1'b1;
                end
            end
            VERT_ACK, HORZ_ACK: begin
                if (bus.clr_cmd_rdy) cmd_rdy_seq_nxt_s = 1'b0; else cmd_rdy_seq_nxt_s = 1'b1;
            end
            VERT_DONE: begin
                if (bus.send_resp) resp_nxt_s = RESP_ACK; else resp_nxt_s = resp_r;
            end
            HORZ_ISSUE: begin
                cmd_seq_nxt_s     = horz_cmd(move_lat_r);
                cmd_rdy_seq_nxt_s = 1'b1;
            end
            HORZ_DONE: begin
                if (bus.send_resp && (mv_indx_r == LAST_IDX)) begin
                    resp_nxt_s      = RESP_END;
                    tour_busy_nxt_s = 1'b0;
                    mv_indx_nxt_s   = '0;
                end else if (bus.send_resp) begin
                    mv_indx_nxt_s   = mv_indx_r + IW'(1);
                end else begin
                    mv_indx_nxt_s   = mv_indx_r;
                end
            end
            ABORT: begin
                // The error byte is presented only for the single ABORT cycle
                resp_nxt_s        = RESP_ACK;
                cmd_rdy_seq_nxt_s = 1'b0;
                tour_busy_nxt_s   = 1'b0;
                mv_indx_nxt_s     = '0;
            end
            default: begin
                cmd_rdy_seq_nxt_s = 1'b0;
                tour_busy_nxt_s   = 1'b0;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mv_indx_r     <= '0;
            move_lat_r    <= 8'h00;
            cmd_seq_r     <= 16'h0000;
            cmd_rdy_seq_r <= 1'b0;
            resp_r        <= RESP_ACK;
            tour_busy_r   <= 1'b0;
        end else begin
            mv_indx_r     <= mv_indx_nxt_s;
            move_lat_r    <= move_lat_nxt_s;
            cmd_seq_r     <= cmd_seq_nxt_s;
            cmd_rdy_seq_r <= cmd_rdy_seq_nxt_s;
            resp_r        <= resp_nxt_s;
            tour_busy_r   <= tour_busy_nxt_s;
        end
    end

    // cmd_rdy is gated by rst so a reset mid-handshake withdraws it without waiting a clock
    assign mv_indx     = mv_indx_r;
    assign tour_busy   = tour_busy_r;
    assign bus.resp    = resp_r;
    assign bus.cmd     = tour_busy_r ? cmd_seq_r : bus.cmd_UART;
    assign bus.cmd_rdy = !rst && (tour_busy_r ? cmd_rdy_seq_r : bus.cmd_rdy_UART);

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Directed bench for tour_cmd_sequencer: idle passthrough, full 24-move tour,
// illegal-move abort, mid-tour reset and ignored stray handshakes.
module tb_tour_cmd_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       start_tour;
    logic [4:0] mv_indx;
    logic [7:0] move;
    logic       tour_busy;
    logic [7:0] store [24];
    int         n_pass = 0;
    int         n_total = 0;

    typedef struct {
        logic [7:0]  mv;
        logic [15:0] v;
        logic [15:0] h;
    } vec_t;
    vec_t vec [8];

    tour_cmd_sequencer_if bus ();

    tour_cmd_sequencer #(.NUM_MOVES(24)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_tour (start_tour),
        .mv_indx    (mv_indx),
        .move       (move),
        .tour_busy  (tour_busy),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;
    assign move = store[mv_indx];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic wait_rdy(input string nm);
        int n = 0;
        while (bus.cmd_rdy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " rdy"}, {15'h0, bus.cmd_rdy}, 16'h0001);
    endtask

    // One command handshake: wait for cmd_rdy, check it, clr, then send_resp
    task automatic do_cmd(input logic [15:0] exp, input int idx, input string nm);
        wait_rdy(nm);
        chk({nm, " cmd"}, bus.cmd, exp);
        chk({nm, " idx"}, {11'h0, mv_indx}, 16'(idx));
        chk({nm, " resp"}, {8'h0, bus.resp}, 16'h00A5);
        bus.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
        chk({nm, " rdy low"}, {15'h0, bus.cmd_rdy}, 16'h0000);
        bus.send_resp = 1'b1;
        @(negedge clk);
        bus.send_resp = 1'b0;
    endtask

    task automatic do_start();
        start_tour = 1'b1;
        @(negedge clk);
        start_tour = 1'b0;
        chk("start busy", {15'h0, tour_busy}, 16'h0001);
        chk("start no fwd", {15'h0, bus.cmd_rdy}, 16'h0000);
    endtask

    initial begin
        vec[0] = '{8'h01, 16'h4002, 16'h5BF1};
        vec[1] = '{8'h02, 16'h4002, 16'h53F1};
        vec[2] = '{8'h04, 16'h4001, 16'h53F2};
        vec[3] = '{8'h08, 16'h47F1, 16'h53F2};
        vec[4] = '{8'h10, 16'h47F2, 16'h53F1};
        vec[5] = '{8'h20, 16'h47F2, 16'h5BF1};
        vec[6] = '{8'h40, 16'h47F1, 16'h5BF2};
        vec[7] = '{8'h80, 16'h4001, 16'h5BF2};
        for (int i = 0; i < 24; i++) store[i] = vec[i % 8].mv;

        rst = 1'b1;
        start_tour = 1'b0;
        bus.cmd_UART = 16'h0000;
        bus.cmd_rdy_UART = 1'b0;
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst idx", {11'h0, mv_indx}, 16'h0000);
        chk("rst busy", {15'h0, tour_busy}, 16'h0000);
        chk("rst resp", {8'h0, bus.resp}, 16'h00A5);
        chk("rst rdy", {15'h0, bus.cmd_rdy}, 16'h0000);

        // Idle passthrough is combinational
        bus.cmd_UART = 16'h4001;
        bus.cmd_rdy_UART = 1'b1;
        #1;
        chk("pass cmd", bus.cmd, 16'h4001);
        chk("pass rdy", {15'h0, bus.cmd_rdy}, 16'h0001);
        @(negedge clk);

        // Full tour with UART rdy held high throughout: it must never leak
        bus.cmd_UART = 16'hDEAD;
        do_start();
        for (int i = 0; i < 24; i++) begin
            do_cmd(vec[i % 8].v, i, $sformatf("tour%0d v", i));
            do_cmd(vec[i % 8].h, i, $sformatf("tour%0d h", i));
        end
        chk("end resp", {8'h0, bus.resp}, 16'h005A);
        chk("end busy", {15'h0, tour_busy}, 16'h0000);
        chk("end idx", {11'h0, mv_indx}, 16'h0000);
        chk("end pass cmd", bus.cmd, 16'hDEAD);
        chk("end pass rdy", {15'h0, bus.cmd_rdy}, 16'h0001);

        // Illegal (zero) move at index 3 aborts
        bus.cmd_rdy_UART = 1'b0;
        store[3] = 8'h00;
        do_start();
        for (int i = 0; i < 3; i++) begin
            do_cmd(vec[i].v, i, $sformatf("ab%0d v", i));
            do_cmd(vec[i].h, i, $sformatf("ab%0d h", i));
        end
        @(negedge clk);
        chk("abort resp", {8'h0, bus.resp}, 16'h00EE);
        chk("abort rdy", {15'h0, bus.cmd_rdy}, 16'h0000);
        @(negedge clk);
        chk("abort idle busy", {15'h0, tour_busy}, 16'h0000);
        chk("abort idle resp", {8'h0, bus.resp}, 16'h00A5);
        chk("abort idle rdy", {15'h0, bus.cmd_rdy}, 16'h0000);
        chk("abort idle idx", {11'h0, mv_indx}, 16'h0000);
        store[3] = vec[3].mv;

        // Reset while HORZ_ACK of move 2
        do_start();
        for (int i = 0; i < 2; i++) begin
            do_cmd(vec[i].v, i, $sformatf("rs%0d v", i));
            do_cmd(vec[i].h, i, $sformatf("rs%0d h", i));
        end
        do_cmd(vec[2].v, 2, "rs2 v");
        wait_rdy("rs2 h");
        chk("rs2 h cmd", bus.cmd, 16'h53F2);
        rst = 1'b1;
        #1;
        chk("rst drop rdy", {15'h0, bus.cmd_rdy}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        chk("rst mid idx", {11'h0, mv_indx}, 16'h0000);
        chk("rst mid busy", {15'h0, tour_busy}, 16'h0000);
        chk("rst mid rdy", {15'h0, bus.cmd_rdy}, 16'h0000);

        // Restart from index 0; the latched move must survive a store change
        do_start();
        do_cmd(16'h4002, 0, "re0 v");
        store[0] = 8'h80;
        do_cmd(16'h5BF1, 0, "re0 h");
        store[0] = vec[0].mv;

        // Stray send_resp and start_tour in VERT_ACK of move 1 are ignored
        wait_rdy("sp v");
        chk("sp cmd", bus.cmd, 16'h4002);
        bus.send_resp = 1'b1;
        start_tour = 1'b1;
        @(negedge clk);
        bus.send_resp = 1'b0;
        start_tour = 1'b0;
        chk("sp hold rdy", {15'h0, bus.cmd_rdy}, 16'h0001);
        chk("sp hold idx", {11'h0, mv_indx}, 16'h0001);
        chk("sp hold cmd", bus.cmd, 16'h4002);
        // clr and send_resp together: only clr acts
        bus.clr_cmd_rdy = 1'b1;
        bus.send_resp = 1'b1;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp = 1'b0;
        chk("sp clr rdy", {15'h0, bus.cmd_rdy}, 16'h0000);
        repeat (2) @(negedge clk);
        chk("sp still done", {15'h0, bus.cmd_rdy}, 16'h0000);
        bus.send_resp = 1'b1;
        @(negedge clk);
        bus.send_resp = 1'b0;
        do_cmd(16'h53F1, 1, "sp h");
        do_cmd(vec[2].v, 2, "sp2 v");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
